// File: rtl/ns_gnrl_arb_pkg.sv
// rtl/ns_gnrl_arb_pkg.sv - shared types and grant-vector helpers for the arbiter output mux
//
// Contents:
//   arb_mux_state_e : IDLE (arbitrating) / LOCKED (a multi-beat packet owns the egress)
//   onehot0_chk     : 1 when the vector has at most one bit set
//   onehot2idx      : bit index of a one-hot vector (0 for an all-zero vector)
// Helpers take a MAX_ARBT-wide vector; callers zero-extend narrower grant vectors.
package ns_gnrl_arb_pkg;

    localparam int MAX_ARBT = 32;
    localparam int MAX_IDW  = $clog2(MAX_ARBT);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_mux_state_e;

    function automatic logic onehot0_chk(input logic [MAX_ARBT-1:0] vec);
        return (vec & (vec - 1'b1)) == '0;
    endfunction

    // OR-ing the indices of all set bits gives the exact index for a one-hot
    // input without a priority chain; multi-hot inputs are rejected elsewhere.
    function automatic logic [MAX_IDW-1:0] onehot2idx(input logic [MAX_ARBT-1:0] vec);
        logic [MAX_IDW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_ARBT; i++) begin
            if (vec[i]) begin
                idx = idx | MAX_IDW'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ns_gnrl_arb_mux_skid1.sv
// rtl/ns_gnrl_arb_mux_skid1.sv - one-entry data+last ingress buffer
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   i_vld / o_rdy    : ingress handshake; o_rdy is ~o_vld (registered state only)
//   i_data, i_last   : ingress payload and end-of-packet
//   i_pop            : consumer takes the held entry this cycle
//   o_vld, o_data, o_last : held entry
// A load needs the entry empty and a pop needs it full, so the two never
// coincide; a popped source can refill on the following cycle at the earliest.
module ns_gnrl_skid1 #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    output logic          o_rdy,
    input  logic [DW-1:0] i_data,
    input  logic          i_last,
    input  logic          i_pop,
    output logic          o_vld,
    output logic [DW-1:0] o_data,
    output logic          o_last
);

    logic          r_vld;
    logic [DW-1:0] r_data;
    logic          r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (i_vld && !r_vld) begin
            r_vld  <= 1'b1;
            r_data <= i_data;
            r_last <= i_last;
        end else if (i_pop) begin
            r_vld  <= 1'b0;
        end
    end

    assign o_rdy  = ~r_vld;
    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_last = r_last;

endmodule

// File: rtl/ns_gnrl_arb_mux.sv
// rtl/ns_gnrl_arb_mux.sv - per-source ingress buffers plus grant-consuming registered output mux
//
// Ports:
//   clk, rst_n                   : clock, asynchronous active-low reset
//   i_in_vld/o_in_rdy            : per-source ingress handshake (ARBT_NUM)
//   i_in_data, i_in_last         : per-source payload (source i at [i*DW +: DW]) and end-of-packet
//   o_req_vec, i_grt_vec         : request to / grant from the round-robin arbiter
//   o_arbt_ena                   : grant consumed this cycle (arbiter advances)
//   o_out_vld/i_out_rdy          : registered egress handshake
//   o_out_data, o_out_last, o_out_id : egress payload, end-of-packet, source index
//   o_err_grt                    : sticky grant protocol error
module ns_gnrl_arb_mux
    import ns_gnrl_arb_pkg::*;
#(
    parameter int ARBT_NUM = 4,
    parameter int DW       = 32,
    parameter int IDW      = $clog2(ARBT_NUM)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ARBT_NUM-1:0]    i_in_vld,
    output logic [ARBT_NUM-1:0]    o_in_rdy,
    input  logic [ARBT_NUM*DW-1:0] i_in_data,
    input  logic [ARBT_NUM-1:0]    i_in_last,
    output logic [ARBT_NUM-1:0]    o_req_vec,
    input  logic [ARBT_NUM-1:0]    i_grt_vec,
    output logic                   o_arbt_ena,
    output logic                   o_out_vld,
    input  logic                   i_out_rdy,
    output logic [DW-1:0]          o_out_data,
    output logic                   o_out_last,
    output logic [IDW-1:0]         o_out_id,
    output logic                   o_err_grt
);

    logic [ARBT_NUM-1:0]         w_buf_vld;
    logic [ARBT_NUM-1:0]         w_buf_last;
    logic [ARBT_NUM-1:0][DW-1:0] w_buf_data;
    logic [ARBT_NUM-1:0]         w_pop;

    arb_mux_state_e  r_state;
    logic [IDW-1:0]  r_owner;
    logic            r_out_vld;
    logic [DW-1:0]   r_out_data;
    logic            r_out_last;
    logic [IDW-1:0]  r_out_id;
    logic            r_err_grt;

    logic [MAX_ARBT-1:0] w_grt_ext;
    logic [IDW-1:0]      w_grt_idx;
    logic [IDW-1:0]      w_sel;
    logic                w_load_ok;
    logic                w_grt_bad;
    logic                w_arbt_ena;
    logic                w_do_load;

    genvar g;
    generate
        for (g = 0; g < ARBT_NUM; g++) begin : g_buf
            ns_gnrl_skid1 #(
                .DW(DW)
            ) u_buf (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_vld  (i_in_vld[g]),
                .o_rdy  (o_in_rdy[g]),
                .i_data (i_in_data[g*DW +: DW]),
                .i_last (i_in_last[g]),
                .i_pop  (w_pop[g]),
                .o_vld  (w_buf_vld[g]),
                .o_data (w_buf_data[g]),
                .o_last (w_buf_last[g])
            );
        end
    endgenerate

    assign w_grt_ext = MAX_ARBT'(i_grt_vec);
    assign w_grt_idx = IDW'(onehot2idx(w_grt_ext));
    assign w_load_ok = ~r_out_vld | i_out_rdy;

    // The grant is only meaningful while arbitrating; a multi-hot grant or a
    // grant to an empty buffer is flagged and never consumed.
    assign w_grt_bad = (r_state == IDLE) &&
                       (!onehot0_chk(w_grt_ext) || ((i_grt_vec & ~w_buf_vld) != '0));

    always_comb begin
        w_arbt_ena = 1'b0;
        w_pop      = '0;
        w_sel      = w_grt_idx;
        if (r_state == IDLE) begin
            w_arbt_ena = w_load_ok && (|i_grt_vec) && !w_grt_bad;
            if (w_arbt_ena) begin
                w_pop = i_grt_vec;
            end
        end else begin
            w_sel = r_owner;
            if (w_load_ok && w_buf_vld[r_owner]) begin
                w_pop[r_owner] = 1'b1;
            end
        end
    end

    assign w_do_load = |w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_last <= 1'b0;
            r_out_id   <= '0;
            r_err_grt  <= 1'b0;
        end else begin
            if (w_grt_bad) begin
                r_err_grt <= 1'b1;
            end

            // Load wins over drain so a simultaneous drain+load sustains one beat per cycle.
            if (w_do_load) begin
                r_out_vld  <= 1'b1;
                r_out_data <= w_buf_data[w_sel];
                r_out_last <= w_buf_last[w_sel];
                r_out_id   <= w_sel;
            end else if (i_out_rdy) begin
                r_out_vld  <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (w_arbt_ena && !w_buf_last[w_grt_idx]) begin
                        r_owner <= w_grt_idx;
                        r_state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_do_load && w_buf_last[r_owner]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_req_vec  = (r_state == IDLE) ? w_buf_vld : '0;
    assign o_arbt_ena = w_arbt_ena;
    assign o_out_vld  = r_out_vld;
    assign o_out_data = r_out_data;
    assign o_out_last = r_out_last;
    assign o_out_id   = r_out_id;
    assign o_err_grt  = r_err_grt;

endmodule

// File: tb/tb_ns_gnrl_arb_mux.sv
// tb/tb_ns_gnrl_arb_mux.sv - self-checking bench for ns_gnrl_arb_mux with a round-robin arbiter model
module tb_ns_gnrl_arb_mux;

    localparam int NSRC = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    logic                clk;
    logic                rst_n;
    logic [NSRC-1:0]     in_vld;
    logic [NSRC-1:0]     in_rdy;
    logic [NSRC*DW-1:0]  in_data;
    logic [NSRC-1:0]     in_last;
    logic [NSRC-1:0]     req_vec;
    logic [NSRC-1:0]     grt_vec;
    logic                arbt_ena;
    logic                out_vld;
    logic                out_rdy;
    logic [DW-1:0]       out_data;
    logic                out_last;
    logic [IDW-1:0]      out_id;
    logic                err_grt;

    int n_checks = 0;
    int n_fail   = 0;

    ns_gnrl_arb_mux #(.ARBT_NUM(NSRC), .DW(DW), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in_vld   (in_vld),
        .o_in_rdy   (in_rdy),
        .i_in_data  (in_data),
        .i_in_last  (in_last),
        .o_req_vec  (req_vec),
        .i_grt_vec  (grt_vec),
        .o_arbt_ena (arbt_ena),
        .o_out_vld  (out_vld),
        .i_out_rdy  (out_rdy),
        .o_out_data (out_data),
        .o_out_last (out_last),
        .o_out_id   (out_id),
        .o_err_grt  (err_grt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Round-robin arbiter: grants the first requester after the last granted one.
    int              rr_ptr;
    logic [NSRC-1:0] grt_rr;
    logic            force_en;
    logic [NSRC-1:0] force_grt;

    always_comb begin
        grt_rr = '0;
        for (int off = 1; off <= NSRC; off++) begin
            if (req_vec[(rr_ptr + off) % NSRC] && grt_rr == '0) begin
                grt_rr[(rr_ptr + off) % NSRC] = 1'b1;
            end
        end
    end

    assign grt_vec = force_en ? force_grt : grt_rr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= NSRC - 1;
        end else if (arbt_ena) begin
            for (int i = 0; i < NSRC; i++) begin
                if (grt_vec[i]) rr_ptr <= i;
            end
        end
    end

    // Source/sink engine: per-source transmit queues, expected queues of
    // accepted beats, egress scoreboard and packet-lock checks.
    logic [DW:0]     tx_q  [NSRC][$];
    logic [DW:0]     exp_q [NSRC][$];
    int              id_log[$];
    logic [NSRC-1:0] pending;
    int              rdy_mode;
    int              egress_cnt;
    logic            lock_valid;
    int              lock_id;

    always @(negedge clk) begin
        logic [DW:0] beat;
        if (!rst_n) begin
            for (int i = 0; i < NSRC; i++) begin
                tx_q[i].delete();
                exp_q[i].delete();
            end
            pending    = '0;
            in_vld     = '0;
            lock_valid = 1'b0;
        end else begin
            for (int i = 0; i < NSRC; i++) begin
                if (pending[i]) exp_q[i].push_back(tx_q[i].pop_front());
            end
            for (int i = 0; i < NSRC; i++) begin
                if (tx_q[i].size() > 0) begin
                    beat = tx_q[i][0];
                    in_vld[i]            = 1'b1;
                    in_data[i*DW +: DW]  = beat[DW-1:0];
                    in_last[i]           = beat[DW];
                end else begin
                    in_vld[i] = 1'b0;
                end
            end
            pending = in_vld & in_rdy;

            if (rdy_mode == 0)      out_rdy = 1'b0;
            else if (rdy_mode == 1) out_rdy = 1'b1;
            else                    out_rdy = ($urandom_range(0, 9) < 7);

            if (out_vld && out_rdy) begin
                n_checks++;
                if (exp_q[out_id].size() == 0) begin
                    n_fail++;
                    $display("FAIL egress_unexpected: id=%0d data=%h, required no beat (source queue empty)", out_id, out_data);
                end else begin
                    beat = exp_q[out_id].pop_front();
                    if ({out_last, out_data} !== beat) begin
                        n_fail++;
                        $display("FAIL egress_beat: id=%0d got last=%0b data=%h, required last=%0b data=%h",
                                 out_id, out_last, out_data, beat[DW], beat[DW-1:0]);
                    end
                end
                n_checks++;
                if (lock_valid && int'(out_id) != lock_id) begin
                    n_fail++;
                    $display("FAIL packet_lock: got id=%0d, required id=%0d", out_id, lock_id);
                end
                lock_valid = !out_last;
                lock_id    = int'(out_id);
                id_log.push_back(int'(out_id));
                egress_cnt++;
            end

            // A non-last beat sitting in the output register means a packet owns the egress.
            if (out_vld && !out_last) begin
                n_checks++;
                if (req_vec !== '0) begin
                    n_fail++;
                    $display("FAIL req_locked: got req_vec=%b, required 0000", req_vec);
                end
            end
        end
    end

    task automatic send(input int src, input logic [DW-1:0] data, input logic last);
        tx_q[src].push_back({last, data});
    endtask

    function automatic logic bench_idle();
        logic idle;
        idle = (pending == '0) && !out_vld;
        for (int i = 0; i < NSRC; i++) begin
            if (tx_q[i].size() != 0 || exp_q[i].size() != 0) idle = 1'b0;
        end
        return idle;
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        for (int c = 0; c < max_cyc; c++) begin
            cycle();
            if (bench_idle()) break;
        end
        n_checks++;
        if (!bench_idle()) begin
            n_fail++;
            $display("FAIL %s_drain: beats still outstanding after %0d cycles, required all delivered", name, max_cyc);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({out_vld, out_data, out_last, out_id, err_grt} !== '0) begin
            n_fail++;
            $display("FAIL reset_out: got vld=%0b data=%h last=%0b id=%0d err=%0b, required all 0",
                     out_vld, out_data, out_last, out_id, err_grt);
        end
        n_checks++;
        if (in_rdy !== 4'b1111 || req_vec !== 4'b0000 || arbt_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got in_rdy=%b req=%b ena=%0b, required 1111 0000 0", in_rdy, req_vec, arbt_ena);
        end
    endtask

    task automatic test_single_beat();
        rdy_mode = 1;
        send(2, 32'h0000_00A5, 1'b1);
        cycle();
        n_checks++;
        if (in_rdy[2] !== 1'b0 || req_vec !== 4'b0100 || arbt_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL single_capture: got in_rdy2=%0b req=%b ena=%0b, required 0 0100 1", in_rdy[2], req_vec, arbt_ena);
        end
        cycle();
        n_checks++;
        if (out_vld !== 1'b1 || out_data !== 32'hA5 || out_id !== 2'd2 || out_last !== 1'b1) begin
            n_fail++;
            $display("FAIL single_out: got vld=%0b data=%h id=%0d last=%0b, required 1 a5 2 1", out_vld, out_data, out_id, out_last);
        end
        n_checks++;
        if (in_rdy[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL single_rdy_back: got in_rdy2=%0b, required 1", in_rdy[2]);
        end
        wait_drain("single", 20);
    endtask

    task automatic test_rotation();
        int start;
        logic [NSRC-1:0] seen;
        rdy_mode = 1;
        start = id_log.size();
        for (int n = 0; n < 6; n++) begin
            for (int s = 0; s < NSRC; s++) send(s, $urandom, 1'b1);
        end
        wait_drain("rotation", 200);
        seen = '0;
        for (int j = start; j < id_log.size(); j++) seen[id_log[j]] = 1'b1;
        n_checks++;
        if (seen !== 4'b1111 || id_log.size() - start != 24) begin
            n_fail++;
            $display("FAIL rotation_cover: got seen=%b beats=%0d, required 1111 24", seen, id_log.size() - start);
        end
        for (int j = start; j + 3 < id_log.size(); j++) begin
            logic [NSRC-1:0] w;
            w = '0;
            for (int k = 0; k < 4; k++) w[id_log[j+k]] = 1'b1;
            n_checks++;
            if (w !== 4'b1111) begin
                n_fail++;
                $display("FAIL rotation_window: at beat %0d got ids %0d %0d %0d %0d, required all distinct",
                         j - start, id_log[j], id_log[j+1], id_log[j+2], id_log[j+3]);
            end
        end
        n_checks++;
        if (err_grt !== 1'b0) begin
            n_fail++;
            $display("FAIL rotation_err: got err_grt=%0b, required 0", err_grt);
        end
    endtask

    task automatic test_packet_lock();
        int start;
        int pos[$];
        rdy_mode = 1;
        start = id_log.size();
        send(1, 32'h1111_0000, 1'b0);
        send(1, 32'h1111_0001, 1'b0);
        send(1, 32'h1111_0002, 1'b1);
        send(0, 32'h0000_0A00, 1'b1);
        send(0, 32'h0000_0A01, 1'b1);
        send(3, 32'h0000_3A00, 1'b1);
        send(3, 32'h0000_3A01, 1'b1);
        wait_drain("lock", 100);
        for (int j = start; j < id_log.size(); j++) begin
            if (id_log[j] == 1) pos.push_back(j);
        end
        n_checks++;
        if (pos.size() != 3) begin
            n_fail++;
            $display("FAIL lock_count: got %0d beats from source 1, required 3", pos.size());
        end else if (pos[1] != pos[0] + 1 || pos[2] != pos[0] + 2) begin
            n_fail++;
            $display("FAIL lock_consecutive: got positions %0d %0d %0d, required consecutive", pos[0], pos[1], pos[2]);
        end
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] held;
        rdy_mode = 0;
        for (int n = 0; n < 2; n++) begin
            for (int s = 0; s < NSRC; s++) send(s, $urandom, 1'b1);
        end
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (out_vld) break;
        end
        n_checks++;
        if (out_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_first_load: got out_vld=%0b, required 1", out_vld);
        end
        held = out_data;
        for (int c = 0; c < 10; c++) begin
            cycle();
            n_checks++;
            if (out_vld !== 1'b1 || out_data !== held || arbt_ena !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold: cycle %0d got vld=%0b data=%h ena=%0b, required 1 %h 0", c, out_vld, out_data, arbt_ena, held);
            end
        end
        n_checks++;
        if (in_rdy !== 4'b0000) begin
            n_fail++;
            $display("FAIL bp_in_rdy: got %b, required 0000", in_rdy);
        end
        rdy_mode = 1;
        wait_drain("bp", 100);
    endtask

    task automatic test_grant_error();
        rdy_mode  = 1;
        force_en  = 1'b1;
        force_grt = 4'b0000;
        send(1, 32'hE1, 1'b1);
        send(2, 32'hE2, 1'b1);
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (in_rdy[2:1] == 2'b00) break;
        end
        n_checks++;
        if (in_rdy[2:1] !== 2'b00 || err_grt !== 1'b0 || out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL err_setup: got in_rdy=%b err=%0b vld=%0b, required xx00x 0 0", in_rdy, err_grt, out_vld);
        end
        force_grt = 4'b0110;
        cycle();
        force_grt = 4'b0000;
        n_checks++;
        if (err_grt !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got err_grt=%0b, required 1", err_grt);
        end
        n_checks++;
        if (in_rdy[2:1] !== 2'b00 || out_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL err_no_pop: got in_rdy=%b out_vld=%0b, required buffers 1,2 held and out_vld 0", in_rdy, out_vld);
        end
        repeat (3) cycle();
        n_checks++;
        if (err_grt !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got err_grt=%0b, required 1", err_grt);
        end
    endtask

    task automatic test_reset_mid_packet();
        int cnt0;
        apply_reset();
        force_en = 1'b0;
        n_checks++;
        if (err_grt !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_err_clear: got err_grt=%0b, required 0", err_grt);
        end
        rdy_mode = 1;
        send(1, 32'hB0, 1'b0);
        send(1, 32'hB1, 1'b0);
        send(1, 32'hB2, 1'b1);
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (out_vld && out_id == 2'd1) break;
        end
        n_checks++;
        if (out_vld !== 1'b1 || out_id !== 2'd1 || out_last !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_first_beat: got vld=%0b id=%0d last=%0b, required 1 1 0", out_vld, out_id, out_last);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_vld !== 1'b0 || in_rdy !== 4'b1111 || req_vec !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_async: got vld=%0b in_rdy=%b req=%b, required 0 1111 0000", out_vld, in_rdy, req_vec);
        end
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        cnt0 = egress_cnt;
        send(0, 32'hC0DE_0000, 1'b1);
        wait_drain("rst_new0", 20);
        send(2, 32'hC0DE_0200, 1'b0);
        send(2, 32'hC0DE_0201, 1'b1);
        send(3, 32'hC0DE_0300, 1'b1);
        wait_drain("rst_new2", 40);
        n_checks++;
        if (egress_cnt - cnt0 != 4) begin
            n_fail++;
            $display("FAIL rst_after: got %0d egress beats, required 4", egress_cnt - cnt0);
        end
    endtask

    task automatic test_random();
        rdy_mode = 2;
        for (int s = 0; s < NSRC; s++) begin
            for (int p = 0; p < 6; p++) begin
                int len;
                len = $urandom_range(1, 3);
                for (int b = 0; b < len; b++) send(s, $urandom, (b == len - 1));
            end
        end
        wait_drain("random", 2000);
        n_checks++;
        if (err_grt !== 1'b0) begin
            n_fail++;
            $display("FAIL random_err: got err_grt=%0b, required 0", err_grt);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_vld     = '0;
        in_data    = '0;
        in_last    = '0;
        out_rdy    = 1'b0;
        force_en   = 1'b0;
        force_grt  = '0;
        rdy_mode   = 1;
        pending    = '0;
        egress_cnt = 0;
        lock_valid = 1'b0;
        lock_id    = 0;

        test_reset();
        test_single_beat();
        test_rotation();
        test_packet_lock();
        test_back_pressure();
        test_random();
        test_grant_error();
        test_reset_mid_packet();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ns_gnrl_arb_mux.md
Name: ns_gnrl_arb_mux

Overview:
- Per-source ingress buffer and grant-consuming output mux that wraps ns_gnrl_rrobin.
- Captures valid/ready beats from ARBT_NUM sources and drives the arbiter's req_vec and arbt_ena.
- Consumes grt_vec to forward the granted beat to a single registered valid/ready egress.
- Supports multi-beat packets: the granted source keeps ownership until a beat with last=1 leaves.

Parameters:
- ARBT_NUM, 4, number of sources. Must be >= 2.
- DW, 32, payload width.
- IDW, $clog2(ARBT_NUM), source-id width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_vld  in  ARBT_NUM  per-source beat valid.
- in_rdy  out  ARBT_NUM  per-source ready; equals ~buf_vld[i].
- in_data  in  ARBT_NUM*DW  per-source payload, packed; source i occupies [i*DW +: DW].
- in_last  in  ARBT_NUM  per-source end-of-packet.
- req_vec  out  ARBT_NUM  to arbiter; equals buf_vld while IDLE, else all zeros.
- grt_vec  in  ARBT_NUM  from arbiter; one-hot or zero.
- arbt_ena  out  1  to arbiter; high when a grant is consumed this cycle.
- out_vld  out  1  egress valid.
- out_rdy  in  1  egress ready.
- out_data  out  DW  egress payload.
- out_last  out  1  egress end-of-packet.
- out_id  out  IDW  source index of the egress beat.
- err_grt  out  1  sticky flag: protocol error on grt_vec.

Behaviour:
- Reset values: buf_vld=0, out_vld=0, out_data=0, out_last=0, out_id=0, err_grt=0, state=IDLE, owner=0.
- Ingress buffer, per source:
  - One entry.
  - Loads when in_vld[i] & in_rdy[i].
  - Clears when popped.
  - No same-cycle load and pop: in_rdy is registered-state only, with no combinational path from grant or out_rdy.
  - Peak rate per source: one beat every 2 cycles.
- load_ok = ~out_vld | out_rdy. The output register is empty or draining this cycle.
- State IDLE:
  - arbt_ena = load_ok & (|grt_vec).
  - When arbt_ena=1 and grt_vec has bit k set:
    - Pop buf[k] into the output register: out_vld=1, data, last, out_id=k.
    - If buf_last[k]=0, set owner=k and go to LOCKED.
- State LOCKED:
  - req_vec=0 and arbt_ena=0; grt_vec is ignored.
  - When load_ok & buf_vld[owner], pop buf[owner] into the output register.
  - If that beat has last=1, return to IDLE.
  - Other sources' buffers hold their beats.
- Output register:
  - Clears out_vld when out_rdy & out_vld and no new load occurs in the same cycle.
  - A simultaneous drain and load is full throughput: one beat per cycle.
- err_grt is set, and stays set until reset, when either of these holds:
  - grt_vec is not one-hot-or-zero.
  - grt_vec selects a source whose buf_vld is 0.
  - On error, no pop occurs and the beat is not loaded.
- Latency: a beat accepted at cycle t reaches out_vld at cycle t+1 at the earliest (IDLE, output empty, arbiter grants combinationally).
- Boundary conditions:
  - out_rdy held low: out_vld and out_data hold stable, arbt_ena stays 0, and ingress buffers fill then back-pressure through in_rdy.
  - Reset asserted mid-packet: all state and buffers are discarded; the FSM returns to IDLE and the partial packet is lost.
  - ARBT_NUM must be a power of two for full id range; otherwise out_id < ARBT_NUM still holds.

Decomposition:
- Package ns_gnrl_arb_pkg holds:
  - enum arb_mux_state_e {IDLE, LOCKED}, 1 bit.
  - Function onehot0_chk(vec).
  - Function onehot2idx(vec).
- Sub-module ns_gnrl_skid1: a one-entry data+last buffer with vld/rdy/pop, instantiated ARBT_NUM times in a generate loop.
- The FSM and output register stay in the top module.
- Test top connects ns_gnrl_arb_mux to ns_gnrl_rrobin via req_vec, grt_vec and arbt_ena.

Test Plan:
- Single beat:
  - Stimulus: source 2 sends data=0xA5, last=1, with out_rdy=1.
  - Required: out_vld at the next cycle with out_data=0xA5, out_id=2, out_last=1; in_rdy[2] returns high one cycle after capture.
- Round-robin rotation:
  - Stimulus: all 4 sources continuously offer single-beat packets.
  - Required: out_id sequence covers 0,1,2,3 with no source repeated within any 4 consecutive egress beats; err_grt stays 0.
- Packet lock:
  - Stimulus: source 1 sends 3 beats (last=0,0,1) while sources 0 and 3 are valid.
  - Required: egress shows three consecutive beats with out_id=1 before any other id; req_vec=0 during LOCKED.
- Back-pressure:
  - Stimulus: out_rdy=0 for 10 cycles with all sources valid.
  - Required: out_data stable, arbt_ena=0 throughout, all in_rdy=0 after the buffers fill; no beat is lost or duplicated after out_rdy=1.
- Grant error:
  - Stimulus: force grt_vec=4'b0110.
  - Required: err_grt=1 the next cycle and stays 1 until reset; no buffer is popped.
- Reset mid-packet:
  - Stimulus: deassert rst_n during LOCKED after beat 1 of 3.
  - Required: immediately out_vld=0, buf_vld=0, state=IDLE; a new packet from source 0 then passes normally.
